// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// master drives operands and result-side ready; slave is the adder itself.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES slices of
// WIDTH/STAGES bits, one register boundary per slice, with a global stall.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_if.slave  bus
);
    localparam int SW = WIDTH / ((STAGES < 1) ? 1 : STAGES);

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
        end
    endgenerate

    logic             w_stall;
    logic [WIDTH-1:0] w_b0;
    logic             w_c0;
    logic [SW:0]      w_slice [STAGES];
    logic [WIDTH-1:0] w_res   [STAGES];

    logic             r_valid [STAGES];
    logic [WIDTH-1:0] r_res   [STAGES];
    logic [WIDTH-1:0] r_a     [STAGES];
    logic [WIDTH-1:0] r_b     [STAGES];
    logic             r_c     [STAGES];
    logic             r_amsb  [STAGES];
    logic             r_bmsb  [STAGES];

    // Subtraction reuses the adder as A + ~B + 1; cin is ignored when sub=1.
    always_comb begin
        w_b0       = bus.sub ? ~bus.b : bus.b;
        w_c0       = bus.sub | bus.cin;
        w_slice[0] = {1'b0, bus.a[SW-1:0]} + {1'b0, w_b0[SW-1:0]} + (SW+1)'(w_c0);
        w_res[0]   = WIDTH'(w_slice[0][SW-1:0]);
        for (int k = 1; k < STAGES; k++) begin
            w_slice[k] = {1'b0, r_a[k-1][SW-1:0]} + {1'b0, r_b[k-1][SW-1:0]}
                       + (SW+1)'(r_c[k-1]);
            w_res[k]   = r_res[k-1];
            w_res[k][k*SW +: SW] = w_slice[k][SW-1:0];
        end
    end

    // Operand registers are kept right-aligned: the next slice is always at bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_res[k]   <= '0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_c[k]     <= 1'b0;
                r_amsb[k]  <= 1'b0;
                r_bmsb[k]  <= 1'b0;
            end
        end else if (!w_stall) begin
            r_valid[0] <= bus.in_valid;
            r_res[0]   <= w_res[0];
            r_a[0]     <= bus.a >> SW;
            r_b[0]     <= w_b0 >> SW;
            r_c[0]     <= w_slice[0][SW];
            r_amsb[0]  <= bus.a[WIDTH-1];
            r_bmsb[0]  <= w_b0[WIDTH-1];
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
                r_res[k]   <= w_res[k];
                r_a[k]     <= r_a[k-1] >> SW;
                r_b[k]     <= r_b[k-1] >> SW;
                r_c[k]     <= w_slice[k][SW];
                r_amsb[k]  <= r_amsb[k-1];
                r_bmsb[k]  <= r_bmsb[k-1];
            end
        end
    end

    assign w_stall       = r_valid[STAGES-1] & ~bus.out_ready;
    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.sum       = r_res[STAGES-1];
    assign bus.cout      = r_c[STAGES-1];
    assign bus.ovf       = (r_amsb[STAGES-1] == r_bmsb[STAGES-1])
                         && (r_res[STAGES-1][WIDTH-1] != r_amsb[STAGES-1]);
endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed scenarios on a 16/4 instance
// plus a random sweep over (8,1), (8,8), (32,4) against an arithmetic model.
module tb_pipelined_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(16)) bus  ();
    pipelined_adder_if #(.WIDTH(8))  s81  ();
    pipelined_adder_if #(.WIDTH(8))  s88  ();
    pipelined_adder_if #(.WIDTH(32)) s324 ();

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
    pipelined_adder #(.WIDTH(8),  .STAGES(1)) u_s81  (.clk(clk), .rst_n(rst_n), .bus(s81));
    pipelined_adder #(.WIDTH(8),  .STAGES(8)) u_s88  (.clk(clk), .rst_n(rst_n), .bus(s88));
    pipelined_adder #(.WIDTH(32), .STAGES(4)) u_s324 (.clk(clk), .rst_n(rst_n), .bus(s324));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    // Plain-integer reference: unsigned result/carry and signed-range overflow.
    function automatic exp_t mk_exp(input int w, input longint unsigned a_u, input longint unsigned b_u,
                                    input bit c, input bit s, input int cyc);
        exp_t   e;
        longint mask, sa, sb, full, sr, lim;
        mask = (longint'(1) << w) - 1;
        sa   = (((a_u >> (w - 1)) & 1) != 0) ? longint'(a_u) - (longint'(1) << w) : longint'(a_u);
        sb   = (((b_u >> (w - 1)) & 1) != 0) ? longint'(b_u) - (longint'(1) << w) : longint'(b_u);
        lim  = longint'(1) << (w - 1);
        if (!s) begin
            full   = longint'(a_u) + longint'(b_u) + longint'(c);
            e.cout = ((full >> w) & 1) != 0;
            sr     = sa + sb + longint'(c);
        end else begin
            full   = longint'(a_u) - longint'(b_u);
            e.cout = (a_u >= b_u);
            sr     = sa - sb;
        end
        e.sum = 32'(full & mask);
        e.ovf = (sr >= lim) || (sr < -lim);
        e.cyc = cyc;
        return e;
    endfunction

    // One clock of the 16/4 instance: apply inputs, sample just before the edge, cross the edge.
    task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                        input logic icin, input logic isub, input logic iordy,
                        output logic ov, output logic [15:0] os, output logic oc,
                        output logic oo, output logic ir);
        bus.in_valid  = iv;
        bus.a         = ia;
        bus.b         = ib;
        bus.cin       = icin;
        bus.sub       = isub;
        bus.out_ready = iordy;
        #1;
        ov = bus.out_valid; os = bus.sum; oc = bus.cout; oo = bus.ovf; ir = bus.in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_vec++; if (bus.sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum got=%h want=0000", bus.sum); end
        n_vec++; if (bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_flags got cout=%b ovf=%b want 0 0", bus.cout, bus.ovf); end
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_out_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_single();
        logic ov, oc, oo, ir;
        logic [15:0] os;
        step(1'b1, 16'h1234, 16'h0FED, 1'b1, 1'b0, 1'b1, ov, os, oc, oo, ir);
        n_vec++; if (ir !== 1'b1) begin n_err++; $display("FAIL single_accept in_ready=%b want=1", ir); end
        for (int k = 1; k <= 5; k++) begin
            step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, ov, os, oc, oo, ir);
            n_vec++;
            if (ov !== (k == 4)) begin n_err++; $display("FAIL single_latency edges=%0d out_valid=%b want=%b", k, ov, (k == 4)); end
            if (k == 4) begin
                n_vec++;
                if (os !== 16'h2222 || oc !== 1'b0 || oo !== 1'b0) begin
                    n_err++; $display("FAIL single_result got sum=%h cout=%b ovf=%b want 2222 0 0", os, oc, oo);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ov, oc, oo, ir;
        logic [15:0] os;
        logic [15:0] ta [8];
        logic [15:0] tb [8];
        logic        tc [8];
        logic        ts [8];
        exp_t e;
        int n_out = 0;
        for (int i = 0; i < 8; i++) begin
            ta[i] = 16'($urandom); tb[i] = 16'($urandom); tc[i] = 1'($urandom); ts[i] = 1'($urandom);
        end
        ta[2] = 16'hFFFF; tb[2] = 16'h0001; tc[2] = 1'b0; ts[2] = 1'b0;
        ta[5] = 16'h7FFF; tb[5] = 16'h0001; tc[5] = 1'b0; ts[5] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < 8) step(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1, ov, os, oc, oo, ir);
            else       step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, ov, os, oc, oo, ir);
            n_vec++; if (ir !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready step=%0d got=%b want=1", i, ir); end
            if (ov === 1'b1 && n_out < 8) begin
                e = mk_exp(16, longint'(ta[n_out]), longint'(tb[n_out]), tc[n_out], ts[n_out], 0);
                n_vec++;
                if (i != 4 + n_out) begin n_err++; $display("FAIL b2b_timing beat=%0d step=%0d want=%0d", n_out, i, 4 + n_out); end
                n_vec++;
                if (os !== e.sum[15:0] || oc !== e.cout || oo !== e.ovf) begin
                    n_err++; $display("FAIL b2b_result beat=%0d got %h/%b/%b want %h/%b/%b", n_out, os, oc, oo, e.sum[15:0], e.cout, e.ovf);
                end
                if (n_out == 2) begin
                    n_vec++; if (os !== 16'h0000 || oc !== 1'b1) begin n_err++; $display("FAIL wrap got sum=%h cout=%b want 0000 1", os, oc); end
                end
                if (n_out == 5) begin
                    n_vec++; if (os !== 16'h8000 || oo !== 1'b1) begin n_err++; $display("FAIL add_ovf got sum=%h ovf=%b want 8000 1", os, oo); end
                end
                n_out++;
            end
        end
        n_vec++; if (n_out != 8) begin n_err++; $display("FAIL b2b_count got=%0d want=8", n_out); end
    endtask

    task automatic test_subtract();
        logic ov, oc, oo, ir;
        logic [15:0] os;
        logic [15:0] xs [2];
        logic        xc [2];
        logic        xo [2];
        int n_out = 0;
        xs[0] = 16'hFFFE; xc[0] = 1'b0; xo[0] = 1'b0;
        xs[1] = 16'h7FFF; xc[1] = 1'b1; xo[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            case (i)
                0:       step(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, ov, os, oc, oo, ir);
                1:       step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, ov, os, oc, oo, ir);
                default: step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, ov, os, oc, oo, ir);
            endcase
            if (ov === 1'b1 && n_out < 2) begin
                n_vec++;
                if (os !== xs[n_out] || oc !== xc[n_out] || oo !== xo[n_out]) begin
                    n_err++; $display("FAIL sub_result beat=%0d got %h/%b/%b want %h/%b/%b", n_out, os, oc, oo, xs[n_out], xc[n_out], xo[n_out]);
                end
                n_out++;
            end
        end
        n_vec++; if (n_out != 2) begin n_err++; $display("FAIL sub_count got=%0d want=2", n_out); end
    endtask

    task automatic test_backpressure();
        exp_t q[$];
        exp_t e;
        logic ov, oc, oo, ir, iv, orr, rc, rs, hc, ho;
        logic [15:0] os, hs, ra, rb;
        int n_in = 0, n_out = 0;
        hs = '0; hc = 1'b0; ho = 1'b0;
        for (int i = 0; i < 26; i++) begin
            iv  = (i < 16);
            orr = !(i >= 6 && i < 11);
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            step(iv, ra, rb, rc, rs, orr, ov, os, oc, oo, ir);
            if (i >= 6 && i <= 10) begin
                n_vec++; if (ir !== 1'b0 || ov !== 1'b1) begin n_err++; $display("FAIL bp_stall step=%0d in_ready=%b out_valid=%b want 0 1", i, ir, ov); end
                if (i == 6) begin hs = os; hc = oc; ho = oo; end
                else begin
                    n_vec++;
                    if (os !== hs || oc !== hc || oo !== ho) begin n_err++; $display("FAIL bp_hold step=%0d got %h/%b/%b want %h/%b/%b", i, os, oc, oo, hs, hc, ho); end
                end
            end
            if (i == 11) begin
                n_vec++; if (ir !== 1'b1 || ov !== 1'b1) begin n_err++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1 1", ir, ov); end
            end
            if (ov === 1'b1 && orr) begin
                n_vec++;
                if (q.size() == 0) begin n_err++; $display("FAIL bp_extra_beat step=%0d got=%h want=none", i, os); end
                else begin
                    e = q.pop_front();
                    if (os !== e.sum[15:0] || oc !== e.cout || oo !== e.ovf) begin
                        n_err++; $display("FAIL bp_result step=%0d got %h/%b/%b want %h/%b/%b", i, os, oc, oo, e.sum[15:0], e.cout, e.ovf);
                    end
                end
                n_out++;
            end
            if (iv && ir === 1'b1) begin q.push_back(mk_exp(16, longint'(ra), longint'(rb), rc, rs, i)); n_in++; end
        end
        n_vec++; if (n_out != n_in || n_in != 11) begin n_err++; $display("FAIL bp_count got in=%0d out=%0d want 11 11", n_in, n_out); end
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        logic ov, oc, oo, ir, iv, orr, rc, rs, hc, ho, prev_stall;
        logic [15:0] os, hs, ra, rb;
        int n_in = 0, n_out = 0;
        prev_stall = 1'b0; hs = '0; hc = 1'b0; ho = 1'b0;
        for (int i = 0; i < 330; i++) begin
            iv  = (i < 300) && ($urandom_range(0, 3) != 0);
            orr = (i >= 300) || ($urandom_range(0, 3) != 0);
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            step(iv, ra, rb, rc, rs, orr, ov, os, oc, oo, ir);
            n_vec++; if (ir !== !(ov && !orr)) begin n_err++; $display("FAIL rnd_in_ready step=%0d got=%b want=%b", i, ir, !(ov && !orr)); end
            if (prev_stall) begin
                n_vec++;
                if (ov !== 1'b1 || os !== hs || oc !== hc || oo !== ho) begin
                    n_err++; $display("FAIL rnd_hold step=%0d got %b %h/%b/%b want 1 %h/%b/%b", i, ov, os, oc, oo, hs, hc, ho);
                end
            end
            prev_stall = ov && !orr; hs = os; hc = oc; ho = oo;
            if (ov === 1'b1 && orr) begin
                n_vec++;
                if (q.size() == 0) begin n_err++; $display("FAIL rnd_extra_beat step=%0d got=%h want=none", i, os); end
                else begin
                    e = q.pop_front();
                    if (os !== e.sum[15:0] || oc !== e.cout || oo !== e.ovf) begin
                        n_err++; $display("FAIL rnd_result step=%0d got %h/%b/%b want %h/%b/%b", i, os, oc, oo, e.sum[15:0], e.cout, e.ovf);
                    end
                end
                n_out++;
            end
            if (iv && ir === 1'b1) begin q.push_back(mk_exp(16, longint'(ra), longint'(rb), rc, rs, i)); n_in++; end
        end
        n_vec++; if (n_out != n_in || q.size() != 0) begin n_err++; $display("FAIL rnd_count got in=%0d out=%0d left=%0d want equal and 0", n_in, n_out, q.size()); end
    endtask

    task automatic test_reset_midflight();
        logic ov, oc, oo, ir;
        logic [15:0] os;
        for (int i = 0; i < 4; i++)
            step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, ov, os, oc, oo, ir);
        bus.in_valid = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre out_valid=%b want=1", bus.out_valid); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_async out_valid=%b want=0", bus.out_valid); end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, ov, os, oc, oo, ir);
            n_vec++; if (ov !== 1'b0) begin n_err++; $display("FAIL midrst_ghost cycle=%0d out_valid=%b want=0", i, ov); end
        end
    endtask

    task automatic test_sweep();
        exp_t qs [3][$];
        exp_t e;
        int   wd [3];
        int   st [3];
        int   outc [3];
        logic        ovl [3];
        logic        ird [3];
        logic        ocs [3];
        logic        oos [3];
        logic [31:0] osm [3];
        logic [31:0] ra, rb, mask;
        logic        rc, rs, iv;
        int acc = 0, cyc = 0;
        wd[0] = 8; wd[1] = 8; wd[2] = 32;
        st[0] = 1; st[1] = 8; st[2] = 4;
        for (int i = 0; i < 3; i++) outc[i] = 0;
        while (cyc < 3000 && (acc < 1000 || qs[0].size() != 0 || qs[1].size() != 0 || qs[2].size() != 0)) begin
            iv = (acc < 1000) && ($urandom_range(0, 3) != 0);
            ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
            s81.in_valid  = iv; s81.a  = ra[7:0]; s81.b  = rb[7:0]; s81.cin  = rc; s81.sub  = rs; s81.out_ready  = 1'b1;
            s88.in_valid  = iv; s88.a  = ra[7:0]; s88.b  = rb[7:0]; s88.cin  = rc; s88.sub  = rs; s88.out_ready  = 1'b1;
            s324.in_valid = iv; s324.a = ra;      s324.b = rb;      s324.cin = rc; s324.sub = rs; s324.out_ready = 1'b1;
            #1;
            ovl[0] = s81.out_valid;  osm[0] = 32'(s81.sum);  ocs[0] = s81.cout;  oos[0] = s81.ovf;  ird[0] = s81.in_ready;
            ovl[1] = s88.out_valid;  osm[1] = 32'(s88.sum);  ocs[1] = s88.cout;  oos[1] = s88.ovf;  ird[1] = s88.in_ready;
            ovl[2] = s324.out_valid; osm[2] = s324.sum;      ocs[2] = s324.cout; oos[2] = s324.ovf; ird[2] = s324.in_ready;
            for (int i = 0; i < 3; i++) begin
                n_vec++; if (ird[i] !== 1'b1) begin n_err++; $display("FAIL sweep_in_ready cfg=%0d cyc=%0d got=%b want=1", i, cyc, ird[i]); end
                if (ovl[i] === 1'b1) begin
                    n_vec++;
                    if (qs[i].size() == 0) begin n_err++; $display("FAIL sweep_extra cfg=%0d cyc=%0d got=%h want=none", i, cyc, osm[i]); end
                    else begin
                        e = qs[i].pop_front();
                        if (osm[i] !== e.sum || ocs[i] !== e.cout || oos[i] !== e.ovf || cyc - e.cyc != st[i]) begin
                            n_err++; $display("FAIL sweep_result cfg=%0d cyc=%0d got %h/%b/%b lat=%0d want %h/%b/%b lat=%0d",
                                              i, cyc, osm[i], ocs[i], oos[i], cyc - e.cyc, e.sum, e.cout, e.ovf, st[i]);
                        end
                    end
                    outc[i]++;
                end
            end
            if (iv) begin
                for (int i = 0; i < 3; i++) begin
                    mask = (wd[i] == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
                    qs[i].push_back(mk_exp(wd[i], longint'(ra & mask), longint'(rb & mask), rc, rs, cyc));
                end
                acc++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (outc[i] != 1000 || acc != 1000) begin n_err++; $display("FAIL sweep_count cfg=%0d got in=%0d out=%0d want 1000 1000", i, acc, outc[i]); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        s81.in_valid  = 1'b0; s81.a  = '0; s81.b  = '0; s81.cin  = 1'b0; s81.sub  = 1'b0; s81.out_ready  = 1'b1;
        s88.in_valid  = 1'b0; s88.a  = '0; s88.b  = '0; s88.cin  = 1'b0; s88.sub  = 1'b0; s88.out_ready  = 1'b1;
        s324.in_valid = 1'b0; s324.a = '0; s324.b = '0; s324.cin = 1'b0; s324.sub = 1'b0; s324.out_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_subtract();
        test_backpressure();
        test_random();
        test_reset_midflight();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached vectors=%0d miscompares=%0d", n_vec, n_err);
        $fatal(1, "time limit");
    end
endmodule
